// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: write-side controller for the 32x32 integer register file.
// Merges single-cycle ALU results with in-order load responses onto the
// single write port. It buffers one load result when the ALU takes the port,
// and tracks outstanding load destinations so decode can stall on RAW hazards.
module rf_wb_ctrl #(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  output logic        ld_issue_ready,
  input  logic        ld_resp_valid,
  input  logic [31:0] ld_resp_data,
  output logic        ld_resp_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        err
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Tag queue of outstanding load destinations, oldest entry at rd_ptr.
  logic [4:0]       q_rd [LQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // One-entry buffer for a load response that lost the port to the ALU.
  // Its destination is always the queue head, so only the data is stored.
  logic             hold_valid;
  logic [31:0]      hold_data;

  logic             q_full;
  logic             q_empty;
  logic [4:0]       head_rd;
  logic             push;
  logic             pop;
  logic             resp_acc;
  logic [LQ_DEPTH-1:0] entry_valid;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             alu_hit;

  assign q_full         = (count == CNT_W'(LQ_DEPTH));
  assign q_empty        = (count == '0);
  assign head_rd        = q_rd[rd_ptr];
  assign ld_issue_ready = !q_full;
  assign ld_resp_ready  = !hold_valid && !q_empty;
  assign push           = ld_issue && ld_issue_ready;
  assign resp_acc       = ld_resp_valid && ld_resp_ready;
  // A load leaves the queue only when its data is handed to the output stage.
  assign pop            = !alu_valid && (hold_valid || resp_acc);

  // Mark which physical slots hold live entries and match them against the
  // hazard queries and the ALU destination.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    entry_valid = '0;
    rs1_hit     = 1'b0;
    rs2_hit     = 1'b0;
    alu_hit     = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      // Slot i is live when its distance from the head is below the count.
      entry_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
      if (entry_valid[i]) begin
        if (q_rd[i] == rs1)    rs1_hit = 1'b1;
        if (q_rd[i] == rs2)    rs2_hit = 1'b1;
        if (q_rd[i] == alu_rd) alu_hit = 1'b1;
      end
    end
  end

  // x0 is never written, so it never has a pending load.
  assign rs1_busy = rs1_hit && (rs1 != 5'd0);
  assign rs2_busy = rs2_hit && (rs2 != 5'd0);

  // Tag storage: write the issued destination at the tail.
  // NOTE: the storage array has no reset; the pointers and count define
  // which slots are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) q_rd[wr_ptr] <= ld_rd;
  end

  // Queue pointers and occupancy count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Write-port arbitration: ALU first, then the held load, then a fresh
  // response; the selected write is registered onto we/waddr/wdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (alu_valid) begin
      we    <= (alu_rd != 5'd0);
      waddr <= alu_rd;
      wdata <= alu_data;
      if (resp_acc) begin
        hold_valid <= 1'b1;
        hold_data  <= ld_resp_data;
      end
    end else if (hold_valid) begin
      we         <= (head_rd != 5'd0);
      waddr      <= head_rd;
      wdata      <= hold_data;
      hold_valid <= 1'b0;
    end else if (resp_acc) begin
      we    <= (head_rd != 5'd0);
      waddr <= head_rd;
      wdata <= ld_resp_data;
    end else begin
      we <= 1'b0;
    end
  end

  // Sticky protocol-violation flag: ALU write racing a pending load to the
  // same register, or a load response with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((alu_valid && (alu_rd != 5'd0) && alu_hit) ||
                 (ld_resp_valid && q_empty)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: self-checking bench for rf_wb_ctrl. A per-cycle vector table
// covers the basic write paths; hand sequences cover queue fill/wrap, x0
// loads, protocol errors and mid-operation reset. Every register-file write
// is matched against a scoreboard of expected {addr, data} pairs.
module tb_rf_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        ld_issue_ready;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic        ld_resp_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  rf_wb_ctrl #(.LQ_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue       (ld_issue),
    .ld_rd          (ld_rd),
    .ld_issue_ready (ld_issue_ready),
    .ld_resp_valid  (ld_resp_valid),
    .ld_resp_data   (ld_resp_data),
    .ld_resp_ready  (ld_resp_ready),
    .rs1            (rs1),
    .rs2            (rs2),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .we             (we),
    .waddr          (waddr),
    .wdata          (wdata),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        iss;
    logic [4:0]  ld_rd;
    logic        resp_v;
    logic [31:0] resp_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_iss_rdy;
    logic        e_resp_rdy;
    logic        e_b1;
    logic        e_b2;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid     = 1'b0;
    alu_rd        = '0;
    alu_data      = '0;
    ld_issue      = 1'b0;
    ld_rd         = '0;
    ld_resp_valid = 1'b0;
    ld_resp_data  = '0;
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
  endtask

  // Write monitor: every we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got waddr=%0d wdata=0x%0h expected no write at %0t",
                 waddr, wdata, $time);
      end else begin
        wr_t w;
        w = sb.pop_front();
        check("wb_addr", 32'(waddr), 32'(w.addr));
        check("wb_data", wdata, w.data);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fields: rst, alu_v, alu_rd, alu_data, iss, ld_rd, resp_v, resp_data, rs1, rs2,
    //         e_iss_rdy, e_resp_rdy, e_b1, e_b2, e_we, e_waddr, e_wdata, e_err
    vecs.push_back('{0,1,5,32'h1234,     0,0, 0,0,            0,0, 1,0,0,0, 1,5,32'h1234,     0});
    vecs.push_back('{0,0,0,0,            0,0, 0,0,            0,0, 1,0,0,0, 0,0,0,            0});
    vecs.push_back('{0,0,0,0,            1,7, 0,0,            7,0, 1,0,0,0, 0,0,0,            0});
    vecs.push_back('{0,0,0,0,            0,0, 0,0,            7,0, 1,1,1,0, 0,0,0,            0});
    vecs.push_back('{0,0,0,0,            0,0, 1,32'hDEADBEEF, 7,7, 1,1,1,1, 1,7,32'hDEADBEEF, 0});
    vecs.push_back('{0,0,0,0,            0,0, 0,0,            7,0, 1,0,0,0, 0,0,0,            0});
    vecs.push_back('{0,0,0,0,            1,3, 0,0,            0,3, 1,0,0,0, 0,0,0,            0});
    vecs.push_back('{0,1,4,32'h44,       0,0, 1,32'h33333333, 0,3, 1,1,0,1, 1,4,32'h44,       0});
    vecs.push_back('{0,0,0,0,            0,0, 0,0,            0,3, 1,0,0,1, 1,3,32'h33333333, 0});
    vecs.push_back('{0,0,0,0,            0,0, 0,0,            0,3, 1,0,0,0, 0,0,0,            0});
    vecs.push_back('{0,0,0,0,            1,9, 0,0,            9,0, 1,0,0,0, 0,0,0,            0});
    vecs.push_back('{0,1,10,32'hA0,      0,0, 1,32'h99,       9,0, 1,1,1,0, 1,10,32'hA0,      0});
    vecs.push_back('{0,1,11,32'hB0,      0,0, 0,0,            9,0, 1,0,1,0, 1,11,32'hB0,      0});
    vecs.push_back('{0,1,12,32'hC0,      0,0, 0,0,            9,0, 1,0,1,0, 1,12,32'hC0,      0});
    vecs.push_back('{0,0,0,0,            0,0, 0,0,            9,0, 1,0,1,0, 1,9,32'h99,       0});
    vecs.push_back('{0,0,0,0,            0,0, 0,0,            9,0, 1,0,0,0, 0,0,0,            0});
    vecs.push_back('{0,0,0,0,            1,6, 0,0,            6,0, 1,0,0,0, 0,0,0,            0});
    vecs.push_back('{0,1,6,32'h66,       0,0, 0,0,            6,0, 1,1,1,0, 1,6,32'h66,       1});
    vecs.push_back('{0,0,0,0,            0,0, 1,32'h600,      6,0, 1,1,1,0, 1,6,32'h600,      1});
    vecs.push_back('{1,0,0,0,            0,0, 0,0,            6,0, 1,0,0,0, 0,0,0,            0});

    // Reset and reset-value checks.
    rst = 1'b1;
    idle();
    rs1 = '0;
    rs2 = '0;
    cyc();
    cyc();
    check("rst_we",        32'(we), 0);
    check("rst_waddr",     32'(waddr), 0);
    check("rst_wdata",     wdata, 0);
    check("rst_err",       32'(err), 0);
    check("rst_iss_rdy",   32'(ld_issue_ready), 1);
    check("rst_resp_rdy",  32'(ld_resp_ready), 0);
    check("rst_rs1_busy",  32'(rs1_busy), 0);
    check("rst_rs2_busy",  32'(rs2_busy), 0);
    rst = 1'b0;

    // Table: inputs held for one cycle; combinational outputs checked in that
    // cycle, registered outputs checked after the edge.
    for (int i = 0; i < vecs.size(); i++) begin
      rst           = vecs[i].rst;
      alu_valid     = vecs[i].alu_v;
      alu_rd        = vecs[i].alu_rd;
      alu_data      = vecs[i].alu_data;
      ld_issue      = vecs[i].iss;
      ld_rd         = vecs[i].ld_rd;
      ld_resp_valid = vecs[i].resp_v;
      ld_resp_data  = vecs[i].resp_data;
      rs1           = vecs[i].rs1;
      rs2           = vecs[i].rs2;
      #1;
      check($sformatf("v%0d_iss_rdy", i),  32'(ld_issue_ready), 32'(vecs[i].e_iss_rdy));
      check($sformatf("v%0d_resp_rdy", i), 32'(ld_resp_ready),  32'(vecs[i].e_resp_rdy));
      check($sformatf("v%0d_rs1_busy", i), 32'(rs1_busy),       32'(vecs[i].e_b1));
      check($sformatf("v%0d_rs2_busy", i), 32'(rs2_busy),       32'(vecs[i].e_b2));
      if (vecs[i].e_we) expect_write(vecs[i].e_waddr, vecs[i].e_wdata);
      cyc();
      check($sformatf("v%0d_we", i),  32'(we),  32'(vecs[i].e_we));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
    end
    rst = 1'b0;
    idle();
    rs1 = '0;
    rs2 = '0;
    check("tbl_rst_waddr", 32'(waddr), 0);
    check("tbl_rst_wdata", wdata, 0);

    // Load to x0: accepted and popped, but never written.
    ld_issue = 1'b1;
    ld_rd    = 5'd0;
    cyc();
    idle();
    #1;
    check("rd0_resp_rdy", 32'(ld_resp_ready), 1);
    ld_resp_valid = 1'b1;
    ld_resp_data  = 32'hABC;
    cyc();
    idle();
    check("rd0_we", 32'(we), 0);
    #1;
    check("rd0_queue_empty", 32'(ld_resp_ready), 0);
    check("rd0_err", 32'(err), 0);

    // Fill the queue, try an overflow issue, drain in order; pointers start
    // offset by one and wrap on each round.
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 4; k++) begin
        ld_issue = 1'b1;
        ld_rd    = 5'(k);
        #1;
        check($sformatf("r%0d_fill%0d_iss_rdy", r, k), 32'(ld_issue_ready), 1);
        cyc();
      end
      ld_issue = 1'b1;
      ld_rd    = 5'd20;
      #1;
      check($sformatf("r%0d_full_iss_rdy", r), 32'(ld_issue_ready), 0);
      cyc();
      ld_issue = 1'b0;
      rs1 = 5'd20;
      #1;
      check($sformatf("r%0d_overflow_dropped", r), 32'(rs1_busy), 0);
      rs1 = 5'd4;
      #1;
      check($sformatf("r%0d_rd4_busy", r), 32'(rs1_busy), 1);
      for (int k = 1; k <= 4; k++) begin
        logic [31:0] d;
        d = {8'(r), 8'(k), 16'hBEEF};
        ld_resp_valid = 1'b1;
        ld_resp_data  = d;
        if (r == 2 && k == 1) begin
          ld_issue = 1'b1;
          ld_rd    = 5'd21;
        end
        #1;
        check($sformatf("r%0d_resp%0d_rdy", r, k), 32'(ld_resp_ready), 1);
        if (r == 2 && k == 1) check("full_pop_iss_rdy", 32'(ld_issue_ready), 0);
        expect_write(5'(k), d);
        cyc();
        ld_issue = 1'b0;
        if (r == 2 && k == 1) check("full_pop_iss_rdy_next", 32'(ld_issue_ready), 1);
      end
      idle();
      cyc();
      rs1 = 5'd21;
      #1;
      check($sformatf("r%0d_rd21_not_busy", r), 32'(rs1_busy), 0);
      check($sformatf("r%0d_drained", r), 32'(ld_resp_ready), 0);
      rs1 = 5'd4;
      #1;
      check($sformatf("r%0d_rd4_clear", r), 32'(rs1_busy), 0);
    end

    // Response with empty queue: dropped, err sticky until reset.
    ld_resp_valid = 1'b1;
    ld_resp_data  = 32'h5;
    #1;
    check("empty_resp_rdy", 32'(ld_resp_ready), 0);
    cyc();
    idle();
    check("empty_resp_err", 32'(err), 1);
    check("empty_resp_we", 32'(we), 0);
    cyc();
    cyc();
    check("err_sticky", 32'(err), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("err_cleared", 32'(err), 0);

    // Mid-operation reset with two loads outstanding.
    ld_issue = 1'b1;
    ld_rd    = 5'd8;
    cyc();
    ld_rd    = 5'd9;
    cyc();
    idle();
    rs1 = 5'd8;
    rs2 = 5'd9;
    #1;
    check("pre_rst_rs1_busy", 32'(rs1_busy), 1);
    check("pre_rst_rs2_busy", 32'(rs2_busy), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("mid_rst_rs1_busy", 32'(rs1_busy), 0);
    check("mid_rst_rs2_busy", 32'(rs2_busy), 0);
    check("mid_rst_we", 32'(we), 0);
    check("mid_rst_iss_rdy", 32'(ld_issue_ready), 1);
    check("mid_rst_resp_rdy", 32'(ld_resp_ready), 0);
    ld_resp_valid = 1'b1;
    ld_resp_data  = 32'h88;
    cyc();
    idle();
    check("stale_resp_err", 32'(err), 1);
    cyc();
    cyc();
    check("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Write-side controller for the 32×32 integer register file. It is the only agent driving the register file's single write port (`we`, `waddr`, `wdata`). It merges single-cycle ALU results with in-order load responses, buffers one load result when the port is contended, and tracks outstanding load destinations so decode can stall on RAW hazards.

## Interface
- `LQ_DEPTH`, default 4: maximum outstanding loads; must be a power of 2, ≥2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `alu_valid`  in  1  ALU result present this cycle; always accepted.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `ld_issue`  in  1  load issued this cycle; takes effect only when `ld_issue_ready`=1.
- `ld_rd`  in  5  destination of the issued load.
- `ld_issue_ready`  out  1  load tag queue not full.
- `ld_resp_valid`  in  1  load data returning, strictly in issue order.
- `ld_resp_data`  in  32  load data.
- `ld_resp_ready`  out  1  response accepted this cycle.
- `rs1`, `rs2`  in  5 each  decode-stage source indices for the hazard query.
- `rs1_busy`, `rs2_busy`  out  1 each  source has an unwritten load pending.
- `we`  out  1  register file write enable (registered).
- `waddr`  out  5  register file write address (registered).
- `wdata`  out  32  register file write data (registered).
- `err`  out  1  sticky protocol-violation flag.

## Operation
- Tag queue: circular FIFO, `LQ_DEPTH` entries of 5-bit rd, read/write pointers plus a count of width clog2(LQ_DEPTH)+1. Push on `ld_issue & ld_issue_ready`. `ld_issue_ready` = !full and does not account for a same-cycle pop.
- Hold register: 1 entry (valid, 32-bit data). Its rd is the queue head.
- `ld_resp_ready` = !hold_valid & queue non-empty.
- Write-port selection each cycle, highest priority first:
  1. `alu_valid`: output stage loads {1, alu_rd, alu_data}. If a response is accepted the same cycle, it goes into the hold register.
  2. `hold_valid`: output stage loads {1, head rd, hold data}; clear hold; pop queue.
  3. Accepted response: output stage loads {1, head rd, ld_resp_data}; pop queue.
  4. Otherwise `we` is 0 next cycle. `waddr` and `wdata` hold their previous values.
- An rd of 0 from either source: `we` is forced to 0. A load entry is still popped.
- Busy query: `rsN_busy` = (rsN≠0) & some valid queue entry has rd==rsN. The check is combinational over all entries. An entry stays busy until the cycle its write is loaded into the output stage. From the next cycle the register file's write bypass supplies the value.
- `err` is set, and stays set until reset, on either condition:
  - `alu_valid` with alu_rd≠0 matching a busy queue entry (WAW ordering violation). The ALU write still proceeds.
  - `ld_resp_valid` while the queue is empty. The response is dropped.
- Reset (including mid-operation) clears the queue, hold register, `we`, `waddr`, `wdata` and `err`. Any response arriving later for a pre-reset load is treated as a protocol error.

## Timing
- Reset values: `we`=0, `waddr`=0, `wdata`=0, `err`=0, `ld_issue_ready`=1, `ld_resp_ready`=0, `rs1_busy`=`rs2_busy`=0.
- ALU accepted in cycle N: `we`=1 in cycle N+1.
- Response accepted in cycle N with no ALU write: `we`=1 in N+1.
- Response accepted in N together with an ALU write: held. It is written in N+2 if N+1 has no ALU write, otherwise on the first ALU-free cycle after that. `ld_resp_ready`=0 while hold is valid.
- Issue in N: `rsN_busy` for that rd asserts in N+1.
- Full queue with simultaneous pop: issue is refused that cycle and `ld_issue_ready` rises in N+1.
- Pointers wrap modulo `LQ_DEPTH`.

## Test plan
- After reset, `alu_valid`=1, rd=5, data=0x1234 in cycle 0 → `we`=1, `waddr`=5, `wdata`=0x1234 in cycle 1; `we`=0 in cycle 2 with no further input.
- Issue a load to rd=7 → `rs1_busy`=1 with `rs1`=7 from the next cycle. Response 0xDEADBEEF with no ALU → next cycle `we`=1, `waddr`=7, `wdata`=0xDEADBEEF, and `rs1_busy`=0.
- Response to rd=3 in the same cycle as an ALU write to rd=4 → cycle+1 writes rd 4; `ld_resp_ready`=0 in cycle+1; cycle+2 writes rd 3 with the load data.
- Issue 4 loads (rd 1–4) → `ld_issue_ready`=0 and a 5th issue is ignored. Return 4 responses → writes occur in order 1, 2, 3, 4. Repeat twice to exercise pointer wrap.
- Load to rd=0, then its response → no write (`we`=0) and the queue empties. A response with the queue empty → `err`=1 and stays 1 until `rst`.
- Two loads outstanding, assert `rst` for one cycle → queue empties, `rsN_busy`=0, `we`=0, `ld_issue_ready`=1.
